// File: rtl/defuse_pkg.sv
// Shared types and constants for the countdown start-value entry block.
package defuse_pkg;

  typedef enum logic [1:0] {IDLE, CONVERT, DONE} state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  function automatic bcd_digit_t bcd_inc(input bcd_digit_t d, input bcd_digit_t max_d);
    return (d >= max_d) ? '0 : bcd_digit_t'(d + 4'd1);
  endfunction

endpackage

// File: rtl/countdown_setter_key_edge_detect.sv
// Single-key press detector: one press per inactive->active transition.
module key_edge_detect #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic key,
  output logic press
);

  logic r_key;
  logic w_active_now;
  logic w_active_prev;

  // History resets to the idle level so releasing reset never looks like a press.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_key <= ACTIVE_LOW;
    else         r_key <= key;
  end

  assign w_active_now  = ACTIVE_LOW ? ~key   : key;
  assign w_active_prev = ACTIVE_LOW ? ~r_key : r_key;
  assign press         = w_active_now & ~w_active_prev;

endmodule

// File: rtl/countdown_setter.sv
// BCD digit entry with iterative BCD->binary conversion of the countdown start value.
module countdown_setter
  import defuse_pkg::*;
#(
  parameter bit          KEY_ACTIVE_LOW = 1'b1,
  parameter int unsigned MAX_HUNDREDS   = 2,
  parameter int unsigned BIN_W          = 10,
  parameter int unsigned OUT_W          = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             key_ones,
  input  logic             key_tens,
  input  logic             key_hundreds,
  input  logic             key_clear,
  input  logic             key_load,
  output logic [3:0]       hundreds,
  output logic [3:0]       tens,
  output logic [3:0]       ones,
  output logic             busy,
  output logic [OUT_W-1:0] value,
  output logic             value_valid,
  output logic             saturated
);

  localparam int unsigned SR_W   = 12 + BIN_W;
  localparam int unsigned ITER_W = $clog2(BIN_W + 1);
  localparam logic [BIN_W-1:0] SAT_LIM = BIN_W'((1 << OUT_W) - 1);
  localparam bcd_digit_t HUND_MAX = bcd_digit_t'(MAX_HUNDREDS);

  logic w_p_ones, w_p_tens, w_p_hund, w_p_clear, w_p_load;

  key_edge_detect #(.ACTIVE_LOW(KEY_ACTIVE_LOW)) u_ked_ones (
    .clk(clk), .resetn(resetn), .key(key_ones), .press(w_p_ones));
  key_edge_detect #(.ACTIVE_LOW(KEY_ACTIVE_LOW)) u_ked_tens (
    .clk(clk), .resetn(resetn), .key(key_tens), .press(w_p_tens));
  key_edge_detect #(.ACTIVE_LOW(KEY_ACTIVE_LOW)) u_ked_hund (
    .clk(clk), .resetn(resetn), .key(key_hundreds), .press(w_p_hund));
  key_edge_detect #(.ACTIVE_LOW(KEY_ACTIVE_LOW)) u_ked_clear (
    .clk(clk), .resetn(resetn), .key(key_clear), .press(w_p_clear));
  key_edge_detect #(.ACTIVE_LOW(KEY_ACTIVE_LOW)) u_ked_load (
    .clk(clk), .resetn(resetn), .key(key_load), .press(w_p_load));

  state_t            r_state, w_state_nx;
  bcd_digit_t        r_hund, r_tens, r_ones;
  bcd_digit_t        w_hund_nx, w_tens_nx, w_ones_nx;
  logic [SR_W-1:0]   r_sr, w_sr_nx, w_sr_adj;
  logic [ITER_W-1:0] r_iter, w_iter_nx;
  logic              r_busy, w_busy_nx;
  logic [OUT_W-1:0]  r_value, w_value_nx;
  logic              r_valid, w_valid_nx;
  logic              r_sat, w_sat_nx;
  logic [BIN_W-1:0]  w_bin;

  // One reverse double-dabble step: shift right, then pull any BCD field >= 8 back by 3.
  always_comb begin
    w_sr_adj = r_sr >> 1;
    for (int unsigned k = 0; k < 3; k++) begin
      if (w_sr_adj[BIN_W + 4*k +: 4] >= 4'd8)
        w_sr_adj[BIN_W + 4*k +: 4] = w_sr_adj[BIN_W + 4*k +: 4] - 4'd3;
    end
  end

  assign w_bin = r_sr[BIN_W-1:0];

  always_comb begin
    w_state_nx = r_state;
    w_hund_nx  = r_hund;
    w_tens_nx  = r_tens;
    w_ones_nx  = r_ones;
    w_sr_nx    = r_sr;
    w_iter_nx  = r_iter;
    w_busy_nx  = r_busy;
    w_value_nx = r_value;
    w_valid_nx = 1'b0;
    w_sat_nx   = r_sat;
    unique case (r_state)
      IDLE: begin
        if (w_p_clear) begin
          w_hund_nx = '0;
          w_tens_nx = '0;
          w_ones_nx = '0;
        end else if (w_p_load) begin
          w_sr_nx    = {r_hund, r_tens, r_ones, {BIN_W{1'b0}}};
          w_iter_nx  = '0;
          w_busy_nx  = 1'b1;
          w_state_nx = CONVERT;
        end else begin
          if (w_p_hund) w_hund_nx = bcd_inc(r_hund, HUND_MAX);
          if (w_p_tens) w_tens_nx = bcd_inc(r_tens, BCD_MAX);
          if (w_p_ones) w_ones_nx = bcd_inc(r_ones, BCD_MAX);
        end
      end
      CONVERT: begin
        w_sr_nx   = w_sr_adj;
        w_iter_nx = r_iter + 1'b1;
        if (r_iter == ITER_W'(BIN_W - 1)) begin
          w_busy_nx  = 1'b0;
          w_state_nx = DONE;
        end
      end
      DONE: begin
        if (w_bin > SAT_LIM) begin
          w_value_nx = '1;
          w_sat_nx   = 1'b1;
        end else begin
          w_value_nx = w_bin[OUT_W-1:0];
          w_sat_nx   = 1'b0;
        end
        w_valid_nx = 1'b1;
        w_state_nx = IDLE;
      end
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_hund  <= '0;
      r_tens  <= '0;
      r_ones  <= '0;
      r_sr    <= '0;
      r_iter  <= '0;
      r_busy  <= 1'b0;
      r_value <= '0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_hund  <= w_hund_nx;
      r_tens  <= w_tens_nx;
      r_ones  <= w_ones_nx;
      r_sr    <= w_sr_nx;
      r_iter  <= w_iter_nx;
      r_busy  <= w_busy_nx;
      r_value <= w_value_nx;
      r_valid <= w_valid_nx;
      r_sat   <= w_sat_nx;
    end
  end

  assign hundreds    = r_hund;
  assign tens        = r_tens;
  assign ones        = r_ones;
  assign busy        = r_busy;
  assign value       = r_value;
  assign value_valid = r_valid;
  assign saturated   = r_sat;

endmodule

// File: tb/tb_countdown_setter.sv
// Directed and random checks of countdown_setter against a cycle-level behavioural model.
module tb_countdown_setter;

  localparam int BIN_W = 10;
  localparam int OUT_W = 8;
  localparam int MAXH  = 2;
  localparam int LAT   = BIN_W + 1;

  // Key bit order used throughout: 0 ones, 1 tens, 2 hundreds, 3 clear, 4 load.
  localparam logic [4:0] K_ONE = 5'b00001, K_TEN = 5'b00010, K_HUN = 5'b00100,
                         K_CLR = 5'b01000, K_LD  = 5'b10000, K_NONE = 5'b00000;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic key_ones = 1'b1, key_tens = 1'b1, key_hundreds = 1'b1, key_clear = 1'b1, key_load = 1'b1;
  logic [3:0] hundreds, tens, ones;
  logic busy, value_valid, saturated;
  logic [OUT_W-1:0] value;

  countdown_setter #(.KEY_ACTIVE_LOW(1'b1), .MAX_HUNDREDS(MAXH), .BIN_W(BIN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .resetn(resetn),
    .key_ones(key_ones), .key_tens(key_tens), .key_hundreds(key_hundreds),
    .key_clear(key_clear), .key_load(key_load),
    .hundreds(hundreds), .tens(tens), .ones(ones),
    .busy(busy), .value(value), .value_valid(value_valid), .saturated(saturated));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: decimal digits plus a countdown to the result pulse.
  int m_h, m_t, m_o;
  int m_cnt, m_pend, m_value;
  bit m_valid, m_sat;
  logic [4:0] m_prev;
  int valid_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("hundreds", 32'(hundreds), 32'(m_h));
    chk("tens", 32'(tens), 32'(m_t));
    chk("ones", 32'(ones), 32'(m_o));
    chk("busy", 32'(busy), 32'(m_cnt >= 2));
    chk("value", 32'(value), 32'(m_value));
    chk("value_valid", 32'(value_valid), 32'(m_valid));
    chk("saturated", 32'(saturated), 32'(m_sat));
    if (value_valid === 1'b1) valid_seen++;
  endtask

  task automatic model_reset();
    m_h = 0; m_t = 0; m_o = 0;
    m_cnt = 0; m_pend = 0; m_value = 0;
    m_valid = 0; m_sat = 0; m_prev = '0;
  endtask

  task automatic model_edge(input logic [4:0] k);
    logic [4:0] p;
    p = k & ~m_prev;
    m_prev = k;
    m_valid = 0;
    if (m_cnt == 0) begin
      if (p[3]) begin
        m_h = 0; m_t = 0; m_o = 0;
      end else if (p[4]) begin
        m_pend = m_h * 100 + m_t * 10 + m_o;
        m_cnt = LAT;
      end else begin
        if (p[0]) m_o = (m_o == 9) ? 0 : m_o + 1;
        if (p[1]) m_t = (m_t == 9) ? 0 : m_t + 1;
        if (p[2]) m_h = (m_h == MAXH) ? 0 : m_h + 1;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1;
        m_sat = (m_pend > 255);
        m_value = m_sat ? 255 : m_pend;
      end
    end
  endtask

  task automatic cyc(input logic [4:0] k);
    key_ones = ~k[0]; key_tens = ~k[1]; key_hundreds = ~k[2];
    key_clear = ~k[3]; key_load = ~k[4];
    @(posedge clk);
    model_edge(k);
    @(negedge clk);
    check_all();
  endtask

  task automatic tap(input logic [4:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      cyc(k);
      cyc(K_NONE);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(K_NONE);
  endtask

  task automatic do_reset();
    key_ones = 1'b1; key_tens = 1'b1; key_hundreds = 1'b1; key_clear = 1'b1; key_load = 1'b1;
    #2 resetn = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    check_all();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // 1: digits 0/4/3 -> 43, single valid pulse.
    tap(K_ONE, 3);
    tap(K_TEN, 4);
    valid_seen = 0;
    cyc(K_LD);
    idle(LAT + 3);
    chk("t1_value", 32'(value), 32'd43);
    chk("t1_valid_count", 32'(valid_seen), 32'd1);

    // 2: wrap without carry.
    tap(K_CLR, 1);
    tap(K_ONE, 10);
    tap(K_HUN, 3);
    chk("t2_ones_wrap", 32'(ones), 32'd0);
    chk("t2_hund_wrap", 32'(hundreds), 32'd0);
    chk("t2_tens_nocarry", 32'(tens), 32'd0);

    // 3: 299 saturates, 255 does not.
    tap(K_HUN, 2); tap(K_TEN, 9); tap(K_ONE, 9);
    cyc(K_LD); idle(LAT + 1);
    chk("t3_sat_value", 32'(value), 32'd255);
    chk("t3_sat_flag", 32'(saturated), 32'd1);
    tap(K_CLR, 1);
    tap(K_HUN, 2); tap(K_TEN, 5); tap(K_ONE, 5);
    cyc(K_LD); idle(LAT + 1);
    chk("t3_255_value", 32'(value), 32'd255);
    chk("t3_255_flag", 32'(saturated), 32'd0);

    // 4: load beats increment; clear beats load.
    tap(K_CLR, 1);
    tap(K_TEN, 1); tap(K_ONE, 7);
    cyc(K_LD | K_TEN); idle(LAT + 1);
    chk("t4_preinc_value", 32'(value), 32'd17);
    chk("t4_tens_kept", 32'(tens), 32'd1);
    cyc(K_CLR | K_LD);
    chk("t4_clear_nobusy", 32'(busy), 32'd0);
    idle(LAT + 1);
    chk("t4_value_kept", 32'(value), 32'd17);

    // 5: presses during conversion are lost; a held key is one press.
    tap(K_ONE, 2);
    cyc(K_LD);
    cyc(K_NONE);
    cyc(K_ONE | K_TEN); cyc(K_NONE); cyc(K_LD); cyc(K_NONE); cyc(K_HUN);
    idle(LAT);
    chk("t5_ones_frozen", 32'(ones), 32'd2);
    chk("t5_value", 32'(value), 32'd2);
    for (int i = 0; i < 20; i++) cyc(K_ONE);
    idle(2);
    chk("t5_held_once", 32'(ones), 32'd3);

    // 6: reset mid-conversion, then 0/1/5 -> 15.
    cyc(K_LD);
    idle(5);
    valid_seen = 0;
    do_reset();
    idle(LAT + 2);
    chk("t6_no_valid", 32'(valid_seen), 32'd0);
    tap(K_TEN, 1); tap(K_ONE, 5);
    cyc(K_LD); idle(LAT + 1);
    chk("t6_value", 32'(value), 32'd15);

    // Random key activity against the model.
    for (int i = 0; i < 600; i++) begin
      logic [4:0] k;
      k[0] = ($urandom_range(0, 2) == 0);
      k[1] = ($urandom_range(0, 2) == 0);
      k[2] = ($urandom_range(0, 3) == 0);
      k[3] = ($urandom_range(0, 24) == 0);
      k[4] = ($urandom_range(0, 7) == 0);
      cyc(k);
    end
    idle(LAT + 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
